// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised rx, mid-bit sampling, one-cycle valid/error strobes.
// Optional parity check is built when PARITY_CHECK_EN is defined.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF     = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL     = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

`ifdef PARITY_CHECK_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
`endif

  state_t               state;
  logic                 rx_m;
  logic                 rx_s;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift;
`ifdef PARITY_CHECK_EN
  logic                 par_bad;
`else
  assign parity_err = 1'b0;
`endif

  // Strobes are registered; busy simply reflects a non-idle state register.
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_m      <= rx;
      rx_s      <= rx_m;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef PARITY_CHECK_EN
      parity_err <= 1'b0;
`endif
      if (!enable) begin
        state   <= IDLE;
        cnt     <= '0;
        bit_idx <= '0;
      end else begin
        case (state)
          IDLE: begin
            cnt <= '0;
            if (!rx_s) state <= START;
          end
          START: begin
            // A high line at mid start bit is treated as a glitch.
            if (cnt == HALF) begin
              cnt <= '0;
              if (!rx_s) begin
                state   <= DATA;
                bit_idx <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          DATA: begin
            if (cnt == FULL) begin
              cnt     <= '0;
              shift   <= {rx_s, shift[DATA_BITS-1:1]};
              bit_idx <= bit_idx + BW'(1);
              if (bit_idx == LAST_BIT) begin
`ifdef PARITY_CHECK_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
`ifdef PARITY_CHECK_EN
          PARITY: begin
            if (cnt == FULL) begin
              cnt     <= '0;
              par_bad <= (rx_s != ((^shift) ^ PARITY_ODD));
              state   <= STOP;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
`endif
          STOP: begin
            if (cnt == FULL) begin
              cnt <= '0;
              if (rx_s) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
`ifdef PARITY_CHECK_EN
                parity_err <= par_bad;
`endif
                state <= IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= WAIT_IDLE;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          WAIT_IDLE: begin
            // Hold off until the line recovers so a break yields a single error.
            cnt <= '0;
            if (rx_s) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised bench for uart_rx: frame-level reference model feeds an expected-event
// queue; an independent monitor pops and compares on every DUT strobe.
module tb_uart_rx;

  localparam int CPB = 16;
  localparam int DB  = 8;
  localparam bit ODD = 1'b0;
`ifdef PARITY_CHECK_EN
  localparam int FRAME_BITS = DB + 3;
`else
  localparam int FRAME_BITS = DB + 2;
`endif
  localparam int W = DB + 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b1;
  logic          rx = 1'b1;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          parity_err;
  logic          busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_valid_cyc = 0;
  int prev_valid_cyc = 0;

  // Event word: {valid, frame_err, parity_err, rx_data}
  logic [W-1:0]  exp_q[$];
  logic [DB-1:0] last_good = '0;

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY_ODD(ODD)) dut (
    .clk(clk), .rst(rst), .enable(enable), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .parity_err(parity_err), .busy(busy)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // reference model: what one frame should produce on the output strobes
  task automatic expect_frame(input logic [DB-1:0] data, input logic stop, input logic par);
    logic perr;
`ifdef PARITY_CHECK_EN
    perr = (par != ((^data) ^ ODD));
`else
    perr = 1'b0;
`endif
    if (stop) begin
      exp_q.push_back({1'b1, 1'b0, perr, data});
      last_good = data;
    end else begin
      exp_q.push_back({1'b0, 1'b1, 1'b0, last_good});
    end
  endtask

  task automatic bit_period(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DB-1:0] data, input logic stop, input logic par);
    bit_period(1'b0);
    for (int i = 0; i < DB; i++) bit_period(data[i]);
`ifdef PARITY_CHECK_EN
    bit_period(par);
`endif
    bit_period(stop);
  endtask

  task automatic good_par(input logic [DB-1:0] data, output logic par);
    par = (^data) ^ ODD;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && (rx_valid || frame_err || parity_err)) begin
      if (rx_valid) begin
        prev_valid_cyc = last_valid_cyc;
        last_valid_cyc = cyc;
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event: got v=%0b fe=%0b pe=%0b data=0x%0h expected none",
                 rx_valid, frame_err, parity_err, rx_data);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if ({rx_valid, frame_err, parity_err, rx_data} !== e) begin
          failures++;
          $display("FAIL event: got v=%0b fe=%0b pe=%0b data=0x%0h expected v=%0b fe=%0b pe=%0b data=0x%0h",
                   rx_valid, frame_err, parity_err, rx_data,
                   e[W-1], e[W-2], e[W-3], e[DB-1:0]);
        end
      end
    end
  end

  initial begin
    logic p;
    logic [DB-1:0] d;
    logic s;
    int seen;
    int n;

    // reset
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_rx_data", 32'(rx_data), 32'h0);
    check("reset_rx_valid", 32'(rx_valid), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_parity_err", 32'(parity_err), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    idle(10);

    // single good frame
    good_par(8'hA5, p);
    expect_frame(8'hA5, 1'b1, p);
    send_frame(8'hA5, 1'b1, p);
    check("busy_after_a5", 32'(busy), 32'h0);
    idle(10);
    check("rx_data_a5", 32'(rx_data), 32'hA5);

    // 4-cycle glitch: busy must rise briefly, no event
    seen = 0;
    rx = 1'b0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); if (busy) seen = 1; end
    rx = 1'b1;
    for (int i = 0; i < 12; i++) begin @(negedge clk); if (busy) seen = 1; end
    check("glitch_busy_seen", 32'(seen), 32'h1);
    idle(20);
    check("glitch_back_idle", 32'(busy), 32'h0);

    // bad stop bit followed by a held-low line
    expect_frame(8'h3C, 1'b0, 1'b0);
    good_par(8'h3C, p);
    send_frame(8'h3C, 1'b0, p);
    rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    check("break_wait_busy", 32'(busy), 32'h1);
    idle(20);
    check("break_rx_data_held", 32'(rx_data), 32'hA5);
    check("break_recovered", 32'(busy), 32'h0);

    // back-to-back with no gap
    good_par(8'h00, p);
    expect_frame(8'h00, 1'b1, p);
    send_frame(8'h00, 1'b1, p);
    good_par(8'hFF, p);
    expect_frame(8'hFF, 1'b1, p);
    send_frame(8'hFF, 1'b1, p);
    idle(20);
    check("b2b_spacing", 32'(last_valid_cyc - prev_valid_cyc), 32'(FRAME_BITS * CPB));
    check("b2b_rx_data", 32'(rx_data), 32'hFF);

    // enable abort in bit 4 of 0x81
    bit_period(1'b0);
    for (int i = 0; i < 4; i++) bit_period(1'(8'h81 >> i));
    rx = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    enable = 1'b0;
    rx = 1'b1;
    repeat (2) @(negedge clk);
    check("enable_abort_busy", 32'(busy), 32'h0);
    repeat (20) @(negedge clk);
    check("enable_abort_hold", 32'(rx_data), 32'hFF);
    enable = 1'b1;
    idle(10);
    good_par(8'h7E, p);
    expect_frame(8'h7E, 1'b1, p);
    send_frame(8'h7E, 1'b1, p);
    idle(10);
    check("after_enable_abort", 32'(rx_data), 32'h7E);

    // reset abort in bit 4 of 0x81
    bit_period(1'b0);
    for (int i = 0; i < 4; i++) bit_period(1'(8'h81 >> i));
    rx = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    rx = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_good = '0;
    @(negedge clk);
    check("rst_abort_data", 32'(rx_data), 32'h0);
    check("rst_abort_busy", 32'(busy), 32'h0);
    idle(10);
    good_par(8'h7E, p);
    expect_frame(8'h7E, 1'b1, p);
    send_frame(8'h7E, 1'b1, p);
    idle(10);
    check("after_rst_abort", 32'(rx_data), 32'h7E);

`ifdef PARITY_CHECK_EN
    // even parity on 0x01 expects parity bit 1
    expect_frame(8'h01, 1'b1, 1'b0);
    send_frame(8'h01, 1'b1, 1'b0);
    idle(8);
    expect_frame(8'h01, 1'b1, 1'b1);
    send_frame(8'h01, 1'b1, 1'b1);
    idle(8);
`endif

    // randomised frames, occasional framing/parity errors, random gaps
    for (int k = 0; k < 24; k++) begin
      d = DB'($urandom_range(0, (1 << DB) - 1));
      s = ($urandom_range(0, 5) != 0);
      good_par(d, p);
      if ($urandom_range(0, 3) == 0) p = ~p;
      expect_frame(d, s, p);
      send_frame(d, s, p);
      if (!s) idle($urandom_range(4, 30));
      else    idle($urandom_range(0, 30));
    end

    // drain with a bound
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    check("final_idle", 32'(busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
